// File: rtl/vga_proc_reader_pkg.sv
// Shared constants for the processed-image VGA display path: 640x480@60 timing,
// image geometry and the pipeline stage record used by vga_proc_reader.
package vga_proc_reader_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int IMG_COLS = 80;
    localparam int IMG_ROWS = 60;
    localparam int CNT_W    = 10;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic visible;
        logic outline;
    } sync_stage_t;

    localparam sync_stage_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, visible: 1'b0, outline: 1'b0};

    // Outermost ring of the active picture.
    function automatic logic is_border(input logic [CNT_W-1:0] col, input logic [CNT_W-1:0] row);
        return (col == '0) || (col == CNT_W'(H_ACTIVE - 1)) ||
               (row == '0) || (row == CNT_W'(V_ACTIVE - 1));
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Free-running 800x525 pixel/line counters with active-region and sync decoding.
// Decoded outputs are combinational from the registered counters.
module vga_sync_gen
    import vga_proc_reader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             active,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             line_end,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign active    = (col_q < CNT_W'(H_ACTIVE)) && (row_q < CNT_W'(V_ACTIVE));
    assign hsync_n   = !((col_q >= HS_START) && (col_q < HS_END));
    assign vsync_n   = !((row_q >= VS_START) && (row_q < VS_END));
    assign line_end  = (col_q == COL_LAST);
    assign frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/vga_proc_reader.sv
// Scans the processed image out to VGA, upscaling each pixel to an 8x8 block.
// Optional VGA_PROC_OUTLINE_EN draws a white frame around the active picture.
module vga_proc_reader
    import vga_proc_reader_pkg::*;
#(
    parameter int c_img_cols    = IMG_COLS,
    parameter int c_img_rows    = IMG_ROWS,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf_gray = 8,
    parameter int c_scale_log2  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [c_nb_img_pxls-1:0] disp_addr,
    input  logic [c_nb_buf_gray-1:0] disp_pxl,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     visible,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue
);

    localparam logic [c_nb_img_pxls-1:0] COLS_STEP = c_nb_img_pxls'(c_img_cols);
    localparam logic [c_nb_img_pxls-1:0] LAST_BASE = c_nb_img_pxls'((c_img_rows - 1) * c_img_cols);

    logic [CNT_W-1:0] col, row;
    logic             active, hsync_n, vsync_n, line_end, frame_end;

    logic [c_scale_log2-1:0]  x_sub_q, x_sub_d;
    logic [c_scale_log2-1:0]  y_sub_q, y_sub_d;
    logic [c_nb_img_pxls-1:0] line_base_q, line_base_d;
    logic [c_nb_img_pxls-1:0] disp_addr_q, disp_addr_d;
    sync_stage_t              pipe_q [3];
    sync_stage_t              pipe_d [3];
    logic [3:0]               pix_q, pix_d;

    vga_sync_gen u_sync (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .active    (active),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // Address walks one image pixel per 8 active columns; blanking parks it on the line base.
    always_comb begin
        x_sub_d     = active ? x_sub_q + 1'b1 : '0;
        disp_addr_d = line_base_q;
        if (active && (col != '0)) begin
            disp_addr_d = (x_sub_q == '0) ? disp_addr_q + 1'b1 : disp_addr_q;
        end
    end

    // Line base steps by one image row every 8 active lines and rewinds at frame end.
    always_comb begin
        y_sub_d     = y_sub_q;
        line_base_d = line_base_q;
        if (frame_end) begin
            y_sub_d     = '0;
            line_base_d = '0;
        end else if (line_end && (row < CNT_W'(V_ACTIVE))) begin
            y_sub_d = y_sub_q + 1'b1;
            if ((y_sub_q == '1) && (line_base_q != LAST_BASE)) begin
                line_base_d = line_base_q + COLS_STEP;
            end
        end
    end

    always_comb begin
        pipe_d[0] = '{hsync_n: hsync_n, vsync_n: vsync_n, visible: active,
                      outline: active && is_border(col, row)};
        pipe_d[1] = pipe_q[0];
        pipe_d[2] = pipe_q[1];
    end

    // Memory data lines up with the second pipeline stage.
    always_comb begin
        pix_d = '0;
        if (pipe_q[1].visible) begin
            pix_d = disp_pxl[c_nb_buf_gray-1 -: 4];
`ifdef VGA_PROC_OUTLINE_EN
            if (pipe_q[1].outline) begin
                pix_d = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_sub_q     <= '0;
            y_sub_q     <= '0;
            line_base_q <= '0;
            disp_addr_q <= '0;
            pix_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
        end else begin
            x_sub_q     <= x_sub_d;
            y_sub_q     <= y_sub_d;
            line_base_q <= line_base_d;
            disp_addr_q <= disp_addr_d;
            pix_q       <= pix_d;
            for (int i = 0; i < 3; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{disp_pxl[c_nb_buf_gray-5:0], pipe_q[1].outline, pipe_q[2].outline};

    assign disp_addr = disp_addr_q;
    assign hsync     = pipe_q[2].hsync_n;
    assign vsync     = pipe_q[2].vsync_n;
    assign visible   = pipe_q[2].visible;
    assign red       = pix_q;
    assign green     = pix_q;
    assign blue      = pix_q;

endmodule

// File: tb/tb_vga_proc_reader.sv
// Self-checking bench for vga_proc_reader: a frame-arithmetic model checked every
// cycle, plus directed literal checks on timing, addressing, colour and reset.
module tb_vga_proc_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] disp_addr;
    logic [7:0]  disp_pxl;
    logic        hsync, vsync, visible;
    logic [3:0]  red, green, blue;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit chk_en       = 1'b0;
    bit pattern      = 1'b0;

    always #20 clk = ~clk;

    vga_proc_reader dut (
        .clk       (clk),
        .rst       (rst),
        .disp_addr (disp_addr),
        .disp_pxl  (disp_pxl),
        .hsync     (hsync),
        .vsync     (vsync),
        .visible   (visible),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    // Memory contents: constant 8'hA7, or an address-dependent pattern.
    function automatic logic [7:0] mem_func(input logic [12:0] a);
        if (!pattern) return 8'hA7;
        return a[7:0] * 8'd29 + 8'h13;
    endfunction

    always @(posedge clk) disp_pxl <= mem_func(disp_addr);

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic int img_addr(input int c, input int r);
        return (c / 8) + (r / 8) * 80;
    endfunction

    // Expected {hsync, vsync, visible, red, green, blue} after k clocks since release.
    function automatic logic [14:0] exp_out(input int k);
        int n, c, r;
        logic hs, vs, vis;
        logic [3:0] nib;
        logic [7:0] d;
        if (k < 3) return {1'b1, 1'b1, 1'b0, 12'h000};
        n   = k - 3;
        c   = n % 800;
        r   = (n / 800) % 525;
        hs  = !(c >= 656 && c < 752);
        vs  = !(r == 490 || r == 491);
        vis = (c < 640) && (r < 480);
        nib = 4'h0;
        if (vis) begin
            d   = mem_func(13'(img_addr(c, r)));
            nib = d[7:4];
`ifdef VGA_PROC_OUTLINE_EN
            if (c == 0 || c == 639 || r == 0 || r == 479) nib = 4'hF;
`endif
        end
        return {hs, vs, vis, nib, nib, nib};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input bit en, input int cycles);
        rst    = rst_val;
        chk_en = en;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_cycle(input int target);
        int guard = 0;
        while (cyc != target && guard < 500000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) checkOutput("wait_cycle_timeout", 32'(cyc), 32'(target));
    endtask

    task automatic wait_level(input bit use_vsync, input logic level, input int budget, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            s = use_vsync ? vsync : hsync;
            if (s === level) begin
                at = cyc;
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        int n, c, r;
        if (chk_en && rst) begin
            checkOutput("outputs", 32'({hsync, vsync, visible, red, green, blue}), 32'(exp_out(cyc)));
            if (cyc >= 1) begin
                n = cyc - 1;
                c = n % 800;
                r = (n / 800) % 525;
                if (c < 640 && r < 480) checkOutput("disp_addr", 32'(disp_addr), 32'(img_addr(c, r)));
            end
        end
    end

    initial begin
        int f1, r1, f2, vf, vr;
        #5 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hsync", 32'(hsync), 32'd1);
        checkOutput("reset_vsync", 32'(vsync), 32'd1);
        checkOutput("reset_visible", 32'(visible), 32'd0);
        checkOutput("reset_rgb", 32'({red, green, blue}), 32'd0);
        checkOutput("reset_addr", 32'(disp_addr), 32'd0);

        applyStimulus(1'b1, 1'b1, 0);
        wait_cycle(1);
        checkOutput("addr_l0_c0", 32'(disp_addr), 32'd0);
        wait_cycle(3);
`ifdef VGA_PROC_OUTLINE_EN
        checkOutput("rgb_col0", 32'({red, green, blue}), 32'hFFF);
`else
        checkOutput("rgb_col0", 32'({red, green, blue}), 32'hAAA);
`endif
        wait_cycle(8);
        checkOutput("addr_l0_c7", 32'(disp_addr), 32'd0);
        wait_cycle(9);
        checkOutput("addr_l0_c8", 32'(disp_addr), 32'd1);
        wait_cycle(640);
        checkOutput("addr_l0_c639", 32'(disp_addr), 32'd79);
        wait_cycle(643);
        checkOutput("blank_rgb", 32'({red, green, blue}), 32'd0);
        checkOutput("blank_visible", 32'(visible), 32'd0);

        wait_level(1'b0, 1'b0, 2000, f1);
        checkOutput("hsync_first_fall", 32'(f1), 32'd659);
        wait_level(1'b0, 1'b1, 2000, r1);
        checkOutput("hsync_low_width", 32'(r1 - f1), 32'd96);
        wait_level(1'b0, 1'b0, 2000, f2);
        checkOutput("hsync_period", 32'(f2 - f1), 32'd800);

        wait_cycle(6401);
        checkOutput("addr_l8_c0", 32'(disp_addr), 32'd80);
        wait_cycle(6411);
        checkOutput("rgb_l8_c8", 32'({red, green, blue}), 32'hAAA);

        wait_cycle(160000);
        pattern = 1'b1;
        applyStimulus(1'b0, 1'b0, 5);
        checkOutput("midreset_hsync", 32'(hsync), 32'd1);
        checkOutput("midreset_visible", 32'(visible), 32'd0);
        applyStimulus(1'b1, 1'b1, 0);

        wait_cycle(11);
        checkOutput("rgb_pattern_addr1", 32'({red, green, blue}), 32'h333);
        wait_level(1'b0, 1'b0, 2000, f1);
        checkOutput("hsync_fall_after_reset", 32'(f1), 32'd659);

        wait_cycle(383840);
        checkOutput("addr_l479_c639", 32'(disp_addr), 32'd4799);
        wait_level(1'b1, 1'b0, 20000, vf);
        checkOutput("vsync_fall", 32'(vf), 32'd392003);
        wait_level(1'b1, 1'b1, 5000, vr);
        checkOutput("vsync_low_width", 32'(vr - vf), 32'd1600);

        wait_cycle(420001);
        checkOutput("frame2_addr_c0", 32'(disp_addr), 32'd0);
        wait_cycle(420009);
        checkOutput("frame2_addr_c8", 32'(disp_addr), 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_proc_reader.md
VGA_PROC_READER -- requirements
Module: vga_proc_reader

Interface
REQ-001 SHALL have parameter c_img_cols, default 80, processed-image width in pixels.
REQ-002 SHALL have parameter c_img_rows, default 60, processed-image height in pixels.
REQ-003 SHALL have parameter c_nb_img_pxls, default 13, processed-memory address width.
REQ-004 SHALL have parameter c_nb_buf_gray, default 8, gray pixel width in memory.
REQ-005 SHALL have parameter c_scale_log2, default 3, so each image pixel becomes an 8x8 screen block.
REQ-006 SHALL have port clk, input, 1, the single clock (25 MHz pixel clock); all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port disp_addr, output, c_nb_img_pxls, read address into the processed-image memory.
REQ-009 SHALL have port disp_pxl, input, c_nb_buf_gray, gray data returned by the memory one clk after disp_addr.
REQ-010 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-011 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-012 SHALL have port visible, output, 1, high while the r/g/b outputs carry an active pixel.
REQ-013 SHALL have ports red, green, blue, output, 4 each, VGA colour.

Function
REQ-014 SHALL run pixel counter col 0..799 and line counter row 0..524; col wraps to 0 after 799 and increments row; row wraps to 0 after 524.
REQ-015 SHALL treat col<640 and row<480 as the active region; hsync is asserted for col 656..751 and vsync for row 490..491.
REQ-016 SHALL build disp_addr incrementally with no multiplier or divider: a 3-bit x sub-count advances the address every 8 active cols; a line-base register advances by c_img_cols every 8 active rows.
REQ-017 SHALL register disp_addr one clk after the counters, so screen (col,row) reads image pixel (col>>3)+(row>>3)*80, range 0..4799.
REQ-018 SHALL hold disp_addr at the current line base during blanking and reset the line base to 0 at row 524, col 799.
REQ-019 SHALL set red=green=blue=disp_pxl[7:4], registered, during active pixels, and drive 0 during blanking.
REQ-020 SHALL delay hsync, vsync and visible through a 3-stage pipeline so they align with the colour outputs; total latency counter->outputs is 3 clk.

Reset
REQ-021 SHALL clear col, row, x/y sub-counts, line base, disp_addr, colours and visible to 0 and set hsync=vsync=1 while rst=0.
REQ-022 SHALL restart cleanly at col=0,row=0 after rst is asserted mid-frame, with no partial-line output carried over.

Configuration
REQ-023 SHALL, when VGA_PROC_OUTLINE_EN is defined, force red=green=blue=4'hF on active col 0, col 639, row 0 and row 479; when undefined those pixels show memory data like any other.

Structure
REQ-024 SHALL take VGA timing constants (640/16/96/48, 480/10/2/33) and the image dimensions from the shared package, together with the edge-processing block.
REQ-025 SHALL place the col/row counters and sync decoding in one sub-module, vga_sync_gen, reusable by other display paths.

Verification
REQ-026 SHALL verify reset: rst=0 -> hsync=vsync=1, colours=0, visible=0, disp_addr=0.
REQ-027 SHALL verify horizontal timing: after release, hsync low for exactly 96 clk with period 800; first hsync fall at clk 659.
REQ-028 SHALL verify vertical timing: vsync low for 1600 clk with period 420000.
REQ-029 SHALL verify addressing: line 0 disp_addr=0 for cols 0-7, 1 for cols 8-15, ..., 79 for cols 632-639; line 8 starts at 80; line 479 ends at 4799; next frame restarts at 0.
REQ-030 SHALL verify colour: memory model returning 8'hA7 -> red=green=blue=4'hA during active pixels and 0 during blanking.
REQ-031 SHALL verify the macro and mid-frame reset: with VGA_PROC_OUTLINE_EN, col 0 shows 4'hF, and without it shows memory data; rst pulsed at row 200 -> next hsync fall again at clk 659 after release.
